led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_pkg.sv | 19 +
 rtl/led_tick_gen.sv | 27 ++
 rtl/led_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_led_seq_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// LED sequencer shared types and constants.
// Holds the FSM state encoding, pattern step modes and PIO register map.
package led_seq_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WRITE,
    READ
  } state_t;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_COUNT  = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic [1:0] LED_DATA_ADDR = 2'd0;

endpackage

// File: rtl/led_tick_gen.sv
// Pattern-step prescaler: one-cycle tick every TICK_DIV enabled clocks.
// The count freezes while enable is low.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer driving an Avalon-MM LED PIO.
// Every pattern step or CPU override is a one-cycle write plus readback check.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [7:0]  seed,
  input  logic        ovr_req,
  input  logic [7:0]  ovr_data,
  output logic        ovr_ack,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        mismatch
);

  logic tick;

  led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .tick   (tick)
  );

  state_t     state_q, state_d;
  logic [7:0] pat_q, pat_d;
  logic [7:0] wr_q, wr_d;
  logic       pend_q, pend_d;
  logic       ph_q, ph_d;
  logic       ovr_q, ovr_d;
  logic       mis_q, mis_d;
  logic [7:0] nxt;
  logic       ph_nxt;
  logic       unused_rd;

  assign unused_rd = ^avm_readdata[31:8];

  always_comb begin
    nxt    = seed;
    ph_nxt = ph_q;
    unique case (mode)
      MODE_STATIC: nxt = seed;
      MODE_ROTATE: nxt = (pat_q == 8'h00) ? seed
                       : {pat_q[6:0], pat_q[7]};
      MODE_COUNT:  nxt = pat_q + 8'd1;
      MODE_BLINK: begin
        nxt    = ph_q ? seed : 8'h00;
        ph_nxt = ~ph_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    wr_d    = wr_q;
    pend_d  = pend_q | tick;
    ph_d    = ph_q;
    ovr_d   = ovr_q;
    mis_d   = mis_q;
    unique case (state_q)
      INIT: begin
        wr_d    = 8'h00;
        ovr_d   = 1'b0;
        state_d = WRITE;
      end
      IDLE: begin
        if (ovr_req) begin
          wr_d    = ovr_data;
          ovr_d   = 1'b1;
          state_d = WRITE;
        end else if (tick || pend_q) begin
          wr_d    = nxt;
          pat_d   = nxt;
          ph_d    = ph_nxt;
          ovr_d   = 1'b0;
          pend_d  = 1'b0;
          state_d = WRITE;
        end
      end
      WRITE: state_d = READ;
      READ: begin
        if (avm_readdata[7:0] != wr_q) mis_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // ph_q=1 means the next blink step shows seed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      pat_q   <= 8'h00;
      wr_q    <= 8'h00;
      pend_q  <= 1'b0;
      ph_q    <= 1'b1;
      ovr_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      wr_q    <= wr_d;
      pend_q  <= pend_d;
      ph_q    <= ph_d;
      ovr_q   <= ovr_d;
      mis_q   <= mis_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign mismatch       = mis_q;
  assign ovr_ack        = (state_q == READ) && ovr_q;
  assign avm_address    = LED_DATA_ADDR;
  assign avm_chipselect = (state_q == WRITE) || (state_q == READ);
  assign avm_write_n    = (state_q != WRITE);
  assign avm_writedata  = (state_q == WRITE) ? {24'h0, wr_q} : 32'h0;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl with an LED PIO slave model.
// Random pattern stepping is scored against a behavioural model.
module tb_led_seq_ctrl;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  seed = 8'h00;
  logic        ovr_req = 1'b0;
  logic [7:0]  ovr_data = 8'h00;
  logic        ovr_ack;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        mismatch;

  led_seq_ctrl #(.TICK_DIV(TD)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .mode          (mode),
    .seed          (seed),
    .ovr_req       (ovr_req),
    .ovr_data      (ovr_data),
    .ovr_ack       (ovr_ack),
    .avm_address   (avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_write_n   (avm_write_n),
    .avm_writedata (avm_writedata),
    .avm_readdata  (avm_readdata),
    .busy          (busy),
    .mismatch      (mismatch)
  );

  always #5 clk = ~clk;

  // LED PIO slave: register with optional bit-0 readback corruption
  logic [7:0] pio = 8'h00;
  logic       corrupt = 1'b0;
  always @(posedge clk)
    if (avm_chipselect && !avm_write_n && avm_address == 2'd0)
      pio <= avm_writedata[7:0];
  assign avm_readdata = {24'h0, pio ^ {7'h0, corrupt}};

  int n_checks = 0;
  int n_fail = 0;
  int cyc, ack_cnt, ack_cyc, bus_bad;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc[$];
  int   m_cnt;
  int   m_pat;
  bit   m_ph;

  task automatic model_tick();
    int v;
    case (mode)
      2'd0: v = seed;
      2'd1: v = (m_pat == 0) ? int'(seed) : ((m_pat * 2) % 256) + (m_pat / 128);
      2'd2: v = (m_pat + 1) % 256;
      default: begin
        v = m_ph ? int'(seed) : 0;
        m_ph = !m_ph;
      end
    endcase
    m_pat = v;
    exp_q.push_back(8'(v));
  endtask

  task automatic step();
    if (enable) begin
      if (m_cnt == TD - 1) begin
        model_tick();
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (avm_chipselect && !avm_write_n) begin
      obs_q.push_back(avm_writedata[7:0]);
      obs_cyc.push_back(cyc);
      if (avm_writedata[31:8] !== 24'h0 || avm_address !== 2'd0) bus_bad++;
    end
    if (!avm_chipselect && (avm_write_n !== 1'b1 || avm_address !== 2'd0
        || avm_writedata !== 32'h0)) bus_bad++;
    if (ovr_ack === 1'b1) begin
      ack_cnt++;
      ack_cyc = cyc;
      ovr_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    corrupt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.push_back(8'h00);
    m_cnt = 0;
    m_pat = 0;
    m_ph = 1'b1;
    cyc = 0;
    ack_cnt = 0;
    ack_cyc = -1;
    bus_bad = 0;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b0;
    ovr_req = 1'b0;
    reset_n = 1'b0;
    #2;
    n_checks++;
    if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || avm_writedata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_bus: cs=%b wn=%b wd=%h want 0/1/0", avm_chipselect, avm_write_n, avm_writedata);
    end
    n_checks++;
    if (ovr_ack !== 1'b0 || mismatch !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_flags: ack=%b mis=%b busy=%b want 0/0/1", ovr_ack, mismatch, busy);
    end
    do_reset();
    step();
    n_checks++;
    if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_writedata !== 32'h0) begin
      n_fail++;
      $display("FAIL init_write: cs=%b wn=%b wd=%h want 1/0/0", avm_chipselect, avm_write_n, avm_writedata);
    end
    step();
    n_checks++;
    if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b1) begin
      n_fail++;
      $display("FAIL init_read: cs=%b wn=%b want 1/1", avm_chipselect, avm_write_n);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || mismatch !== 1'b0 || avm_chipselect !== 1'b0) begin
      n_fail++;
      $display("FAIL init_done: busy=%b mis=%b cs=%b want 0/0/0", busy, mismatch, avm_chipselect);
    end
  endtask

  task automatic test_rotate();
    logic [7:0] want[3];
    want[0] = 8'h81;
    want[1] = 8'h03;
    want[2] = 8'h06;
    mode = 2'd1;
    seed = 8'h81;
    enable = 1'b1;
    do_reset();
    for (int i = 0; i < 60 && obs_q.size() < 4; i++) step();
    n_checks++;
    if (obs_q.size() < 4) begin
      n_fail++;
      $display("FAIL rot_count: got %0d writes want 4", obs_q.size());
      return;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_q[i+1] !== want[i]) begin
        n_fail++;
        $display("FAIL rot_val%0d: got %h want %h", i, obs_q[i+1], want[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (obs_cyc[i+1] - obs_cyc[i] != TD) begin
        n_fail++;
        $display("FAIL rot_space%0d: got %0d want %0d", i, obs_cyc[i+1] - obs_cyc[i], TD);
      end
    end
  endtask

  task automatic test_wrap();
    mode = 2'd0;
    seed = 8'hFE;
    enable = 1'b1;
    do_reset();
    for (int i = 0; i < 40 && obs_q.size() < 2; i++) step();
    mode = 2'd2;
    for (int i = 0; i < 60 && obs_q.size() < 4; i++) step();
    n_checks++;
    if (obs_q.size() < 4) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d writes want 4", obs_q.size());
      return;
    end
    n_checks++;
    if (obs_q[2] !== 8'hFF || obs_q[3] !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_vals: got %h,%h want ff,00", obs_q[2], obs_q[3]);
    end
  endtask

  task automatic test_random();
    int n;
    enable = 1'b0;
    do_reset();
    repeat (3) step();
    for (int s = 0; s < 60; s++) begin
      mode = 2'($urandom_range(0, 3));
      seed = 8'($urandom);
      enable = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 6)) step();
    end
    enable = 1'b0;
    repeat (4) step();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_val%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (bus_bad != 0 || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_bus: got %0d bad cycles mis=%b want 0/0", bus_bad, mismatch);
    end
  endtask

  task automatic test_override();
    mode = 2'd2;
    seed = 8'h00;
    enable = 1'b1;
    do_reset();
    for (int i = 0; i < 20 && !(m_cnt == TD - 1 && busy === 1'b0); i++) step();
    ovr_data = 8'h5A;
    ovr_req = 1'b1;
    for (int i = 0; i < 60 && obs_q.size() < 4; i++) step();
    repeat (3) step();
    ovr_req = 1'b0;
    n_checks++;
    if (obs_q.size() < 4) begin
      n_fail++;
      $display("FAIL ovr_count: got %0d writes want 4", obs_q.size());
      return;
    end
    n_checks++;
    if (obs_q[1] !== 8'h5A || obs_q[2] !== 8'h01 || obs_q[3] !== 8'h02) begin
      n_fail++;
      $display("FAIL ovr_order: got %h,%h,%h want 5a,01,02", obs_q[1], obs_q[2], obs_q[3]);
    end
    n_checks++;
    if (ack_cnt != 1 || ack_cyc != obs_cyc[1] + 1) begin
      n_fail++;
      $display("FAIL ovr_ack: got %0d pulses at %0d want 1 at %0d", ack_cnt, ack_cyc, obs_cyc[1] + 1);
    end
    n_checks++;
    if (obs_cyc[2] - ack_cyc != 2) begin
      n_fail++;
      $display("FAIL ovr_tick_gap: got %0d want 2", obs_cyc[2] - ack_cyc);
    end
  endtask

  task automatic test_mismatch();
    mode = 2'd0;
    seed = 8'h10;
    enable = 1'b1;
    do_reset();
    repeat (3) step();
    n_checks++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_clean: got %b want 0", mismatch);
    end
    corrupt = 1'b1;
    for (int i = 0; i < 20 && obs_q.size() < 2; i++) step();
    repeat (2) step();
    corrupt = 1'b0;
    n_checks++;
    if (mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_set: got %b want 1", mismatch);
    end
    repeat (12) step();
    n_checks++;
    if (mismatch !== 1'b1 || obs_q.size() < 4) begin
      n_fail++;
      $display("FAIL mis_sticky: got %b after %0d writes want 1", mismatch, obs_q.size());
    end
    reset_n = 1'b0;
    #2;
    n_checks++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_reset: got %b want 0", mismatch);
    end
  endtask

  task automatic test_reset_mid();
    mode = 2'd0;
    seed = 8'h77;
    enable = 1'b0;
    do_reset();
    repeat (3) step();
    ovr_data = 8'h5A;
    ovr_req = 1'b1;
    for (int i = 0; i < 10 && !(avm_chipselect && !avm_write_n); i++) step();
    n_checks++;
    if (avm_writedata !== 32'h5A) begin
      n_fail++;
      $display("FAIL mid_write: got %h want 0000005a", avm_writedata);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || ovr_ack !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_abort: cs=%b wn=%b ack=%b busy=%b want 0/1/0/1", avm_chipselect, avm_write_n, ovr_ack, busy);
    end
    do_reset();
    step();
    n_checks++;
    if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_writedata !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_init: cs=%b wn=%b wd=%h want 1/0/0", avm_chipselect, avm_write_n, avm_writedata);
    end
    step();
    n_checks++;
    if (ovr_ack !== 1'b0 || ack_cnt != 0) begin
      n_fail++;
      $display("FAIL mid_noack: got ack=%b count %0d want 0", ovr_ack, ack_cnt);
    end
    repeat (6) step();
    n_checks++;
    if (obs_q.size() != 2 || obs_q[1] !== 8'h5A || ack_cnt != 1) begin
      n_fail++;
      $display("FAIL mid_ovr_after: got %0d writes acks %0d want 2 writes, 1 ack", obs_q.size(), ack_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_wrap();
    test_random();
    test_override();
    test_mismatch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
